// File: rtl/seq_detector_moore_wrapper.sv
// Board wrapper: Moore FSM flagging runs of three or more consecutive 1s on ain, plus a 4-bit detect-cycle counter.
// Optional define INPUT_SYNC_EN inserts a 2-flop synchronizer on ain ahead of the FSM.
module seq_detector_moore_wrapper #(
  parameter int unsigned COUNT_SAT = 0
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic       ain,
  output logic [3:0] count,
  output logic       detected
);

  localparam int unsigned CountW = 4;
  localparam logic [CountW-1:0] CountMax = {CountW{1'b1}};

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              ain_fsm;
  logic [CountW-1:0] count_next;

`ifdef INPUT_SYNC_EN
  logic [1:0] sync_q;

  // Two-stage synchronizer; cleared by reset like the rest of the design.
  always_ff @(posedge sys_clock) begin
    if (!reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], ain};
    end
  end

  assign ain_fsm = sync_q[1];
`else
  assign ain_fsm = ain;
`endif

  // State, flag and counter registers; reset wins over ain.
  always_ff @(posedge sys_clock) begin
    if (!reset) begin
      state    <= S0;
      detected <= 1'b0;
      count    <= '0;
    end else begin
      state    <= state_next;
      detected <= (state_next == S3);
      count    <= count_next;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_next = S0;
    count_next = count;
    case (state)
      S0:      state_next = ain_fsm ? S1 : S0;
      S1:      state_next = ain_fsm ? S2 : S0;
      S2:      state_next = ain_fsm ? S3 : S0;
      S3:      state_next = ain_fsm ? S3 : S0;
      default: state_next = S0;
    endcase
    if (state_next == S3) begin
      if ((COUNT_SAT != 0) && (count == CountMax)) begin
        count_next = count;
      end else begin
        count_next = count + CountW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_moore_wrapper.sv
// Self-checking bench: wrapping and saturating instances checked against a run-length reference model.
module tb_seq_detector_moore_wrapper;

`ifdef INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       sys_clock = 1'b0;
  logic       reset     = 1'b0;
  logic       ain       = 1'b0;
  logic [3:0] count_w;
  logic       detected_w;
  logic [3:0] count_s;
  logic       detected_s;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: length of the current run of 1s seen by the FSM, and detect counters.
  int run_len   = 0;
  int cnt_wrap  = 0;
  int cnt_sat   = 0;
  bit dly_hist [$];

  seq_detector_moore_wrapper #(.COUNT_SAT(0)) dut (
    .sys_clock(sys_clock), .reset(reset), .ain(ain),
    .count(count_w), .detected(detected_w)
  );

  seq_detector_moore_wrapper #(.COUNT_SAT(1)) dut_sat (
    .sys_clock(sys_clock), .reset(reset), .ain(ain),
    .count(count_s), .detected(detected_s)
  );

  always #5 sys_clock = ~sys_clock;

  // Apply one cycle of stimulus, advance the model, and leave time just after the edge.
  task automatic step(input bit r, input bit a);
    bit eff;
    reset = r;
    ain   = a;
    @(posedge sys_clock);
    #1;
    if (!r) begin
      run_len  = 0;
      cnt_wrap = 0;
      cnt_sat  = 0;
      dly_hist.delete();
      for (int i = 0; i < LAT; i++) dly_hist.push_back(1'b0);
    end else begin
      dly_hist.push_back(a);
      eff = dly_hist.pop_front();
      run_len = eff ? ((run_len < 1000) ? run_len + 1 : run_len) : 0;
      if (run_len >= 3) begin
        cnt_wrap = (cnt_wrap + 1) % 16;
        cnt_sat  = (cnt_sat < 15) ? cnt_sat + 1 : 15;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      step(i >= 2, 1'b0);
      n_cmp++;
      if (detected_w !== 1'b0 || count_w !== 4'd0) begin
        n_err++;
        $display("FAIL reset[%0d]: detected=%b count=%0d, required detected=0 count=0", i, detected_w, count_w);
      end
      n_cmp++;
      if (detected_s !== 1'b0 || count_s !== 4'd0) begin
        n_err++;
        $display("FAIL reset_sat[%0d]: detected=%b count=%0d, required detected=0 count=0", i, detected_s, count_s);
      end
    end
  endtask

  task automatic test_short_run();
    bit pat [3] = '{1'b1, 1'b1, 1'b0};
    step(1'b0, 1'b0);
    for (int i = 0; i < 3 + LAT; i++) begin
      step(1'b1, (i < 3) ? pat[i] : 1'b0);
      n_cmp++;
      if (detected_w !== 1'b0 || count_w !== 4'd0) begin
        n_err++;
        $display("FAIL short_run[%0d]: detected=%b count=%0d, required detected=0 count=0", i, detected_w, count_w);
      end
    end
  endtask

  task automatic test_run4();
    bit exp_det;
    int exp_cnt;
    step(1'b0, 1'b0);
    for (int i = 0; i < 7 + LAT; i++) begin
      step(1'b1, i < 4);
      exp_det = (i == 2 + LAT) || (i == 3 + LAT);
      exp_cnt = (i < 2 + LAT) ? 0 : ((i == 2 + LAT) ? 1 : 2);
      n_cmp++;
      if (detected_w !== exp_det || count_w !== 4'(exp_cnt)) begin
        n_err++;
        $display("FAIL run4[%0d]: detected=%b count=%0d, required detected=%b count=%0d",
                 i, detected_w, count_w, exp_det, exp_cnt);
      end
    end
  endtask

  task automatic test_long_run();
    step(1'b0, 1'b0);
    for (int i = 0; i < 18 + LAT; i++) begin
      step(1'b1, 1'b1);
      n_cmp++;
      if (count_w !== 4'(cnt_wrap) || count_s !== 4'(cnt_sat) || detected_w !== (run_len >= 3)) begin
        n_err++;
        $display("FAIL long_run[%0d]: wrap=%0d sat=%0d det=%b, required wrap=%0d sat=%0d det=%b",
                 i, count_w, count_s, detected_w, cnt_wrap, cnt_sat, run_len >= 3);
      end
    end
    n_cmp++;
    if (count_w !== 4'd0 || count_s !== 4'd15) begin
      n_err++;
      $display("FAIL long_run_end: wrap=%0d sat=%0d, required wrap=0 sat=15", count_w, count_s);
    end
  endtask

  task automatic test_mid_reset();
    bit exp_det;
    step(1'b0, 1'b0);
    for (int i = 0; i < 5 + LAT; i++) step(1'b1, 1'b1);
    n_cmp++;
    if (detected_w !== 1'b1 || count_w !== 4'd3) begin
      n_err++;
      $display("FAIL mid_reset_pre: detected=%b count=%0d, required detected=1 count=3", detected_w, count_w);
    end
    step(1'b0, 1'b1);
    n_cmp++;
    if (detected_w !== 1'b0 || count_w !== 4'd0 || count_s !== 4'd0) begin
      n_err++;
      $display("FAIL mid_reset_edge: detected=%b count=%0d sat=%0d, required 0/0/0", detected_w, count_w, count_s);
    end
    for (int i = 0; i < 3 + LAT; i++) begin
      step(1'b1, 1'b1);
      exp_det = (i == 2 + LAT);
      n_cmp++;
      if (detected_w !== exp_det || count_w !== 4'(exp_det ? 1 : 0)) begin
        n_err++;
        $display("FAIL mid_reset_redetect[%0d]: detected=%b count=%0d, required detected=%b count=%0d",
                 i, detected_w, count_w, exp_det, exp_det ? 1 : 0);
      end
    end
  endtask

  task automatic test_random();
    bit r;
    bit a;
    step(1'b0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 59) != 0);
      a = ($urandom_range(0, 99) < 75);
      step(r, a);
      n_cmp++;
      if (detected_w !== (run_len >= 3) || count_w !== 4'(cnt_wrap)) begin
        n_err++;
        $display("FAIL random_wrap[%0d]: detected=%b count=%0d, required detected=%b count=%0d",
                 i, detected_w, count_w, run_len >= 3, cnt_wrap);
      end
      n_cmp++;
      if (detected_s !== (run_len >= 3) || count_s !== 4'(cnt_sat)) begin
        n_err++;
        $display("FAIL random_sat[%0d]: detected=%b count=%0d, required detected=%b count=%0d",
                 i, detected_s, count_s, run_len >= 3, cnt_sat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_short_run();
    test_run4();
    test_long_run();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
